// File: rtl/pipe_pkg.sv
// Shared widths, control-bundle bit positions and per-edge action encoding for
// the RV32I pipeline registers.
package pipe_pkg;

   localparam int unsigned XLEN       = 32;
   localparam int unsigned REG_ADDR_W = 5;
   localparam int unsigned CTRL_W     = 16;

   localparam int unsigned CTRL_REGWEN  = 0;
   localparam int unsigned CTRL_MEMREAD = 1;

   typedef enum logic [1:0] {
      ActLoad      = 2'd0,
      ActHold      = 2'd1,
      ActFlush     = 2'd2,
      ActInterlock = 2'd3
   } action_e;

   typedef struct packed {
      logic                  valid;
      logic [XLEN-1:0]       pc;
      logic [XLEN-1:0]       rs1_data;
      logic [XLEN-1:0]       rs2_data;
      logic [XLEN-1:0]       imm;
      logic [REG_ADDR_W-1:0] rs1;
      logic [REG_ADDR_W-1:0] rs2;
      logic [REG_ADDR_W-1:0] rd;
      logic [CTRL_W-1:0]     ctrl;
   } id_ex_t;

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard compare between a load in a later stage and
// the instruction currently in ID.
module load_use_detect
   import pipe_pkg::*;
(
   input  logic                  ex_valid,
   input  logic                  ex_memread,
   input  logic [REG_ADDR_W-1:0] rd_ex,
   input  logic                  id_valid,
   input  logic                  id_uses_rs1,
   input  logic [REG_ADDR_W-1:0] id_rs1,
   input  logic                  id_uses_rs2,
   input  logic [REG_ADDR_W-1:0] id_rs2,
   output logic                  load_use
);

   logic rs1_hit;
   logic rs2_hit;

   assign rs1_hit  = id_uses_rs1 && (id_rs1 == rd_ex);
   assign rs2_hit  = id_uses_rs2 && (id_rs2 == rd_ex);
   // x0 is never written, so a load targeting it cannot create a hazard.
   assign load_use = ex_valid && ex_memread && (rd_ex != '0) && id_valid && (rs1_hit || rs2_hit);

endmodule

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register with load-use interlock, redirect flush and memory-stall hold.
// Optional PIPE_PERF_CNT_EN adds interlock/flush event counters.
module id_ex_pipe_reg
   import pipe_pkg::*;
(
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  id_valid,
   input  logic [XLEN-1:0]       id_pc,
   input  logic [XLEN-1:0]       id_rs1_data,
   input  logic [XLEN-1:0]       id_rs2_data,
   input  logic [XLEN-1:0]       id_imm,
   input  logic [REG_ADDR_W-1:0] id_rs1,
   input  logic [REG_ADDR_W-1:0] id_rs2,
   input  logic [REG_ADDR_W-1:0] id_rd,
   input  logic                  id_uses_rs1,
   input  logic                  id_uses_rs2,
   input  logic [CTRL_W-1:0]     id_ctrl,
   input  logic                  ex_redirect,
   input  logic                  mem_stall,
   output logic                  stall_if_id,
   output logic                  ex_valid,
   output logic [XLEN-1:0]       ex_pc,
   output logic [XLEN-1:0]       ex_rs1_data,
   output logic [XLEN-1:0]       ex_rs2_data,
   output logic [XLEN-1:0]       ex_imm,
   output logic [REG_ADDR_W-1:0] rs1_ex,
   output logic [REG_ADDR_W-1:0] rs2_ex,
   output logic [REG_ADDR_W-1:0] rd_ex,
   output logic [CTRL_W-1:0]     ex_ctrl
`ifdef PIPE_PERF_CNT_EN
   ,
   output logic [31:0]           load_use_cnt,
   output logic [31:0]           flush_cnt
`endif
);

   id_ex_t  stage_q;
   id_ex_t  stage_d;
   id_ex_t  id_fields;
   logic    load_use;
   action_e action;

   load_use_detect u_load_use_detect (
      .ex_valid    (stage_q.valid),
      .ex_memread  (stage_q.ctrl[CTRL_MEMREAD]),
      .rd_ex       (stage_q.rd),
      .id_valid    (id_valid),
      .id_uses_rs1 (id_uses_rs1),
      .id_rs1      (id_rs1),
      .id_uses_rs2 (id_uses_rs2),
      .id_rs2      (id_rs2),
      .load_use    (load_use)
   );

   always_comb begin
      if (mem_stall) begin
         action = ActHold;
      end else if (ex_redirect) begin
         action = ActFlush;
      end else if (load_use) begin
         action = ActInterlock;
      end else begin
         action = ActLoad;
      end
   end

   // A redirect discards the ID instruction, so there is nothing to hold for.
   assign stall_if_id = (load_use && !ex_redirect) || mem_stall;

   always_comb begin
      id_fields = '{
         valid:    id_valid,
         pc:       id_pc,
         rs1_data: id_rs1_data,
         rs2_data: id_rs2_data,
         imm:      id_imm,
         rs1:      id_rs1,
         rs2:      id_rs2,
         rd:       id_rd,
         ctrl:     id_ctrl
      };
   end

   always_comb begin
      stage_d = stage_q;
      unique case (action)
         ActLoad:                stage_d = id_fields;
         ActHold:                stage_d = stage_q;
         ActFlush, ActInterlock: stage_d = '0;
         default:                stage_d = '0;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stage_q <= '0;
      end else begin
         stage_q <= stage_d;
      end
   end

   assign ex_valid    = stage_q.valid;
   assign ex_pc       = stage_q.pc;
   assign ex_rs1_data = stage_q.rs1_data;
   assign ex_rs2_data = stage_q.rs2_data;
   assign ex_imm      = stage_q.imm;
   assign rs1_ex      = stage_q.rs1;
   assign rs2_ex      = stage_q.rs2;
   assign rd_ex       = stage_q.rd;
   assign ex_ctrl     = stage_q.ctrl;

`ifdef PIPE_PERF_CNT_EN
   logic [31:0] load_use_cnt_q;
   logic [31:0] flush_cnt_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         load_use_cnt_q <= '0;
         flush_cnt_q    <= '0;
      end else begin
         if (action == ActInterlock) load_use_cnt_q <= load_use_cnt_q + 32'd1;
         if (action == ActFlush)     flush_cnt_q    <= flush_cnt_q + 32'd1;
      end
   end

   assign load_use_cnt = load_use_cnt_q;
   assign flush_cnt    = flush_cnt_q;
`endif

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Directed table-driven bench for id_ex_pipe_reg; counter checks apply when
// PIPE_PERF_CNT_EN is defined.
module tb_id_ex_pipe_reg;
   import pipe_pkg::*;

   logic              clk = 1'b0;
   logic              reset;
   logic              id_valid;
   logic [31:0]       id_pc, id_rs1_data, id_rs2_data, id_imm;
   logic [4:0]        id_rs1, id_rs2, id_rd;
   logic              id_uses_rs1, id_uses_rs2;
   logic [15:0]       id_ctrl;
   logic              ex_redirect, mem_stall;
   logic              stall_if_id, ex_valid;
   logic [31:0]       ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
   logic [4:0]        rs1_ex, rs2_ex, rd_ex;
   logic [15:0]       ex_ctrl;
`ifdef PIPE_PERF_CNT_EN
   logic [31:0]       load_use_cnt, flush_cnt;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   id_ex_pipe_reg dut (
      .clk         (clk),
      .reset       (reset),
      .id_valid    (id_valid),
      .id_pc       (id_pc),
      .id_rs1_data (id_rs1_data),
      .id_rs2_data (id_rs2_data),
      .id_imm      (id_imm),
      .id_rs1      (id_rs1),
      .id_rs2      (id_rs2),
      .id_rd       (id_rd),
      .id_uses_rs1 (id_uses_rs1),
      .id_uses_rs2 (id_uses_rs2),
      .id_ctrl     (id_ctrl),
      .ex_redirect (ex_redirect),
      .mem_stall   (mem_stall),
      .stall_if_id (stall_if_id),
      .ex_valid    (ex_valid),
      .ex_pc       (ex_pc),
      .ex_rs1_data (ex_rs1_data),
      .ex_rs2_data (ex_rs2_data),
      .ex_imm      (ex_imm),
      .rs1_ex      (rs1_ex),
      .rs2_ex      (rs2_ex),
      .rd_ex       (rd_ex),
      .ex_ctrl     (ex_ctrl)
`ifdef PIPE_PERF_CNT_EN
      ,
      .load_use_cnt(load_use_cnt),
      .flush_cnt   (flush_cnt)
`endif
   );

   typedef struct {
      logic        valid;
      logic [31:0] pc;
      logic [4:0]  rs1, rs2, rd;
      logic        u1, u2;
      logic [15:0] ctrl;
      logic        redir, mstall;
      logic        e_stall, e_valid;
      logic [31:0] e_pc;
      logic [4:0]  e_rs1, e_rs2, e_rd;
      logic [15:0] e_ctrl;
      int          e_lu, e_fl;
   } vec_t;

   vec_t vecs[15];

   function automatic logic [31:0] dat(input logic [31:0] pc, input logic [15:0] tag);
      return (pc == 32'h0) ? 32'h0 : {tag, pc[15:0]};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [31:0] pc, input logic [4:0] r1,
                        input logic [4:0] r2, input logic [4:0] rd, input logic u1,
                        input logic u2, input logic [15:0] ctrl, input logic redir,
                        input logic ms);
      id_valid    = v;
      id_pc       = pc;
      id_rs1_data = {16'hA000, pc[15:0]};
      id_rs2_data = {16'hB000, pc[15:0]};
      id_imm      = {16'hC000, pc[15:0]};
      id_rs1      = r1;
      id_rs2      = r2;
      id_rd       = rd;
      id_uses_rs1 = u1;
      id_uses_rs2 = u2;
      id_ctrl     = ctrl;
      ex_redirect = redir;
      mem_stall   = ms;
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, " ex_valid"}, {31'b0, ex_valid}, 32'h0);
      chk({tag, " ex_pc"}, ex_pc, 32'h0);
      chk({tag, " rd_ex"}, {27'b0, rd_ex}, 32'h0);
      chk({tag, " rs1_ex"}, {27'b0, rs1_ex}, 32'h0);
      chk({tag, " ex_ctrl"}, {16'b0, ex_ctrl}, 32'h0);
      chk({tag, " ex_rs1_data"}, ex_rs1_data, 32'h0);
`ifdef PIPE_PERF_CNT_EN
      chk({tag, " load_use_cnt"}, load_use_cnt, 32'h0);
      chk({tag, " flush_cnt"}, flush_cnt, 32'h0);
`endif
   endtask

   initial begin
      //            v  pc       r1 r2 rd  u1 u2 ctrl      rd ms | st ev e_pc    er1 er2 erd ectrl   lu fl
      vecs[0]  = '{1, 32'h100, 1, 2, 5,  1, 1, 16'h0011, 0, 0,  0, 1, 32'h100, 1, 2, 5,  16'h0011, 0, 0};
      vecs[1]  = '{1, 32'h104, 2, 0, 7,  1, 0, 16'h0003, 0, 0,  0, 1, 32'h104, 2, 0, 7,  16'h0003, 0, 0};
      vecs[2]  = '{1, 32'h108, 7, 3, 8,  1, 1, 16'h0011, 0, 0,  1, 0, 32'h0,   0, 0, 0,  16'h0000, 1, 0};
      vecs[3]  = '{1, 32'h108, 7, 3, 8,  1, 1, 16'h0011, 0, 0,  0, 1, 32'h108, 7, 3, 8,  16'h0011, 1, 0};
      vecs[4]  = '{1, 32'h10C, 4, 0, 0,  1, 0, 16'h0003, 0, 0,  0, 1, 32'h10C, 4, 0, 0,  16'h0003, 1, 0};
      vecs[5]  = '{1, 32'h110, 0, 0, 9,  1, 0, 16'h0011, 0, 0,  0, 1, 32'h110, 0, 0, 9,  16'h0011, 1, 0};
      vecs[6]  = '{1, 32'h114, 1, 0, 7,  1, 0, 16'h0003, 0, 0,  0, 1, 32'h114, 1, 0, 7,  16'h0003, 1, 0};
      vecs[7]  = '{1, 32'h118, 3, 7, 10, 1, 1, 16'h0011, 1, 0,  0, 0, 32'h0,   0, 0, 0,  16'h0000, 1, 1};
      vecs[8]  = '{1, 32'h11C, 1, 0, 6,  1, 0, 16'h0003, 0, 0,  0, 1, 32'h11C, 1, 0, 6,  16'h0003, 1, 1};
      vecs[9]  = '{1, 32'h120, 6, 6, 11, 0, 0, 16'h0001, 0, 0,  0, 1, 32'h120, 6, 6, 11, 16'h0001, 1, 1};
      vecs[10] = '{0, 32'h124, 2, 3, 12, 1, 1, 16'h0011, 0, 0,  0, 0, 32'h124, 2, 3, 12, 16'h0011, 1, 1};
      vecs[11] = '{1, 32'h128, 12, 0, 13, 1, 0, 16'h0011, 1, 1, 1, 0, 32'h124, 2, 3, 12, 16'h0011, 1, 1};
      vecs[12] = '{1, 32'h128, 12, 0, 13, 1, 0, 16'h0011, 1, 1, 1, 0, 32'h124, 2, 3, 12, 16'h0011, 1, 1};
      vecs[13] = '{1, 32'h128, 12, 0, 13, 1, 0, 16'h0011, 1, 1, 1, 0, 32'h124, 2, 3, 12, 16'h0011, 1, 1};
      vecs[14] = '{1, 32'h128, 12, 0, 13, 1, 0, 16'h0011, 1, 0, 0, 0, 32'h0,   0, 0, 0,  16'h0000, 1, 2};

      reset = 1'b1;
      drive(0, 32'h0, 0, 0, 0, 0, 0, 16'h0, 0, 0);
      repeat (2) @(posedge clk);
      #1;
      chk_zero("reset");
      chk("reset stall_if_id", {31'b0, stall_if_id}, 32'h0);
      @(negedge clk);
      reset = 1'b0;

      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         drive(vecs[i].valid, vecs[i].pc, vecs[i].rs1, vecs[i].rs2, vecs[i].rd, vecs[i].u1,
               vecs[i].u2, vecs[i].ctrl, vecs[i].redir, vecs[i].mstall);
         #1;
         chk($sformatf("v%0d stall_if_id", i), {31'b0, stall_if_id}, {31'b0, vecs[i].e_stall});
         @(posedge clk);
         #1;
         chk($sformatf("v%0d ex_valid", i), {31'b0, ex_valid}, {31'b0, vecs[i].e_valid});
         chk($sformatf("v%0d ex_pc", i), ex_pc, vecs[i].e_pc);
         chk($sformatf("v%0d rs1_ex", i), {27'b0, rs1_ex}, {27'b0, vecs[i].e_rs1});
         chk($sformatf("v%0d rs2_ex", i), {27'b0, rs2_ex}, {27'b0, vecs[i].e_rs2});
         chk($sformatf("v%0d rd_ex", i), {27'b0, rd_ex}, {27'b0, vecs[i].e_rd});
         chk($sformatf("v%0d ex_ctrl", i), {16'b0, ex_ctrl}, {16'b0, vecs[i].e_ctrl});
         chk($sformatf("v%0d ex_rs1_data", i), ex_rs1_data, dat(vecs[i].e_pc, 16'hA000));
         chk($sformatf("v%0d ex_rs2_data", i), ex_rs2_data, dat(vecs[i].e_pc, 16'hB000));
         chk($sformatf("v%0d ex_imm", i), ex_imm, dat(vecs[i].e_pc, 16'hC000));
`ifdef PIPE_PERF_CNT_EN
         chk($sformatf("v%0d load_use_cnt", i), load_use_cnt, vecs[i].e_lu);
         chk($sformatf("v%0d flush_cnt", i), flush_cnt, vecs[i].e_fl);
`endif
      end

      // Asynchronous reset while an interlock is pending.
      @(negedge clk);
      drive(1, 32'h200, 1, 0, 7, 1, 0, 16'h0003, 0, 0);
      @(posedge clk);
      @(negedge clk);
      drive(1, 32'h204, 7, 0, 8, 1, 0, 16'h0011, 0, 0);
      #1;
      chk("mid stall_if_id before reset", {31'b0, stall_if_id}, 32'h1);
      #1;
      reset = 1'b1;
      #1;
      chk_zero("async reset");
      chk("async reset stall_if_id", {31'b0, stall_if_id}, 32'h0);
      mem_stall = 1'b1;
      #1;
      chk("reset+mem_stall stall_if_id", {31'b0, stall_if_id}, 32'h1);
      @(negedge clk);
      mem_stall = 1'b0;
      reset     = 1'b0;
      @(posedge clk);
      #1;
      chk("post-reset ex_valid", {31'b0, ex_valid}, 32'h1);
      chk("post-reset rd_ex", {27'b0, rd_ex}, 32'h8);
      chk("post-reset rs1_ex", {27'b0, rs1_ex}, 32'h7);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish, expected completion");
      $fatal(1);
   end

endmodule

// File: doc/id_ex_pipe_reg.md
# id_ex_pipe_reg

ID/EX pipeline register of the RV32I 5-stage core, with integrated load-use interlock and branch-flush handling. It captures decoded operands and control from ID each cycle and presents them to EX as rs1_ex/rs2_ex/rd_ex plus data and control. The forwarding unit and ALU operand muxes consume these outputs. It also generates the IF/ID hold signal and inserts bubbles on load-use hazards and on EX-stage redirects.

## Interface
- XLEN, 32, datapath width
- CTRL_W, 16, width of packed control bundle; bit CTRL_REGWEN and bit CTRL_MEMREAD positions come from the package
- clk  in  1  core clock, rising edge
- reset  in  1  asynchronous, active-high reset; one clock domain (clk)
- id_valid  in  1  ID holds a real instruction
- id_pc, id_rs1_data, id_rs2_data, id_imm  in  XLEN each  decoded PC, register-file reads, immediate
- id_rs1, id_rs2, id_rd  in  5 each  register addresses
- id_uses_rs1, id_uses_rs2  in  1 each  instruction actually reads rs1/rs2
- id_ctrl  in  CTRL_W  control bundle (RegWEn, MemRead, ALU op, ...)
- ex_redirect  in  1  EX resolved taken branch/jump this cycle
- mem_stall  in  1  MA waiting on data memory; freezes whole pipe
- stall_if_id  out  1  hold PC and IF/ID (combinational)
- ex_valid  out  1  EX holds a real instruction
- ex_pc, ex_rs1_data, ex_rs2_data, ex_imm  out  XLEN each
- rs1_ex, rs2_ex, rd_ex  out  5 each
- ex_ctrl  out  CTRL_W

## Operation
- Load-use hazard (comb): ex_valid & ex_ctrl[CTRL_MEMREAD] & rd_ex!=0 & id_valid & ((id_uses_rs1 & id_rs1==rd_ex) | (id_uses_rs2 & id_rs2==rd_ex)).
- Per-edge action, priority order:
  - reset: all registers 0.
  - mem_stall=1: HOLD, all outputs keep value.
  - ex_redirect=1: FLUSH, load bubble (the ID instruction is wrong-path).
  - load-use: INTERLOCK, load bubble.
  - else LOAD: capture all id_* fields; ex_valid <= id_valid.
- Bubble: ex_valid=0, ex_ctrl=0, rs1_ex=rs2_ex=rd_ex=0, all data fields 0. A bubble therefore never asserts RegWEn downstream and never forwards.
- stall_if_id = load_use & ~ex_redirect, OR'd with mem_stall.
- Load-use lasts exactly one cycle. After the bubble, ex_valid=0 clears the hazard and the held ID instruction loads on the next edge.
- ex_redirect together with mem_stall: HOLD wins. EX is frozen, so redirect is re-presented and FLUSH occurs on the first non-stalled edge.
- id_valid=0 with no hazard: loads a bubble-equivalent (ex_valid=0). Field values are still captured but ignored downstream.
- Reset mid-stall: registers clear immediately. stall_if_id drops unless mem_stall is high.

## Timing
- Latency: id_* to ex_* is 1 cycle (registered on rising clk).
- stall_if_id is combinational and valid in the same cycle as the hazard. The IF/ID stage must sample it on the same edge.
- All outputs are 0 while reset is asserted and after release until the first LOAD.
- No multicycle paths. Hazard compare is 5-bit equality only.

## Configuration
- PIPE_PERF_CNT_EN defined:
  - Adds outputs load_use_cnt[31:0] and flush_cnt[31:0], both reset to 0 and wrapping at 2^32.
  - load_use_cnt +1 on each INTERLOCK edge.
  - flush_cnt +1 on each FLUSH edge.
  - Neither counter increments on HOLD.
- Undefined: the counter ports and logic are absent. Behaviour is otherwise identical.

## Structure
- pipe_pkg holds:
  - XLEN, REG_ADDR_W=5, CTRL_W.
  - CTRL_REGWEN and CTRL_MEMREAD bit indices.
  - The action encoding localparam: LOAD/HOLD/FLUSH/INTERLOCK, 2-bit.
- Sub-module load_use_detect: pure combinational hazard compare, instantiated once. Reusable by a future MA-stage interlock.

## Test plan
- Straight-line: id_valid=1, id_rd=5, id_ctrl RegWEn=1 → next cycle rd_ex=5, ex_valid=1, stall_if_id=0.
- Load-use: EX holds lw with rd_ex=7; ID holds add using rs1=7 → stall_if_id=1 this cycle, then bubble (ex_ctrl=0). The next cycle loads the add with rs1_ex=7. With PIPE_PERF_CNT_EN, load_use_cnt goes from 0 to 1.
- x0 exemption: lw with rd_ex=0, ID uses rs1=0 → no stall, add loads directly.
- Redirect + hazard: ex_redirect=1 while load-use holds → FLUSH bubble, stall_if_id=0, flush_cnt=1, load_use_cnt unchanged.
- mem_stall=1 for 3 cycles with ex_redirect=1 → outputs frozen and stall_if_id=1 throughout. FLUSH occurs on the first edge after mem_stall drops.
- Reset asserted mid-INTERLOCK (asynchronous) → all outputs 0 immediately and counters 0.
